pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl.sv | 83 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and pipe_hazard_ctrl (slave).
// sel_src1/sel_src2 exist only when FORWARD_EN is defined.
interface pipe_hazard_ctrl_if;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_two_src;
    logic [3:0]  exe_dest;
    logic        exe_wb_en;
    logic        exe_mem_r_en;
    logic [3:0]  mem_dest;
    logic        mem_wb_en;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        hazard_freeze;
    logic        if_id_flush;
    logic        id_exe_flush;
    logic        global_freeze;
    logic        mem_timeout;
    logic [15:0] stall_cycles;
`ifdef FORWARD_EN
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
`endif

    modport master (
        output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
        input  hazard_freeze, if_id_flush, id_exe_flush, global_freeze,
               mem_timeout, stall_cycles
`ifdef FORWARD_EN
        , input sel_src1, sel_src2
`endif
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
        output hazard_freeze, if_id_flush, id_exe_flush, global_freeze,
               mem_timeout, stall_cycles
`ifdef FORWARD_EN
        , output sel_src1, sel_src2
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stall/flush, branch flush, memory-wait freeze with timeout.
// Define FORWARD_EN to stall on load-use only and expose forwarding selects.
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16
) (
    input logic            clk,
    input logic            rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    // Timeout fires on the edge that carries wait_cnt from MAX_WAIT-1 to MAX_WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        mem_timeout_q;
    logic [15:0] stall_q;

    logic raw_exe, raw_mem, data_hz, gfrz, hfrz;

    assign raw_exe = hz.exe_wb_en & ((hz.id_src1 == hz.exe_dest) |
                                     (hz.id_two_src & (hz.id_src2 == hz.exe_dest)));
    assign raw_mem = hz.mem_wb_en & ((hz.id_src1 == hz.mem_dest) |
                                     (hz.id_two_src & (hz.id_src2 == hz.mem_dest)));

`ifdef FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic use_src,
                                           input logic [3:0] e_dst, input logic e_wb,
                                           input logic [3:0] m_dst, input logic m_wb);
        if (use_src && e_wb && src == e_dst)      return 2'b01;
        else if (use_src && m_wb && src == m_dst) return 2'b10;
        else                                      return 2'b00;
    endfunction

    // Only a load in EXE cannot be forwarded in time.
    assign data_hz     = raw_exe & hz.exe_mem_r_en;
    assign hz.sel_src1 = fwd_sel(hz.id_src1, 1'b1, hz.exe_dest, hz.exe_wb_en,
                                 hz.mem_dest, hz.mem_wb_en);
    assign hz.sel_src2 = fwd_sel(hz.id_src2, hz.id_two_src, hz.exe_dest, hz.exe_wb_en,
                                 hz.mem_dest, hz.mem_wb_en);
`else
    logic unused_mem_r_en;
    assign unused_mem_r_en = hz.exe_mem_r_en;
    assign data_hz         = raw_exe | raw_mem;
`endif

    // Priority: memory freeze, then branch, then data hazard. A branch held in the
    // frozen EXE register flushes on the first unfrozen cycle.
    assign gfrz             = hz.mem_req & ~hz.mem_ready;
    assign hfrz             = ~gfrz & ~hz.branch_taken & data_hz;
    assign hz.global_freeze = gfrz;
    assign hz.hazard_freeze = hfrz;
    assign hz.if_id_flush   = ~gfrz & hz.branch_taken;
    assign hz.id_exe_flush  = ~gfrz & (hz.branch_taken | data_hz);
    assign hz.mem_timeout   = mem_timeout_q;
    assign hz.stall_cycles  = stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            wait_cnt      <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_q       <= 16'd0;
        end else begin
            if ((hfrz | gfrz) && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            case (state)
                RUN: if (gfrz) state <= MEM_WAIT;
                MEM_WAIT: begin
                    if (gfrz) begin
                        if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) mem_timeout_q <= 1'b1;
                    end else begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: default instance (MAX_WAIT=16) and MAX_WAIT=3 instance.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if if_a ();
    pipe_hazard_ctrl_if if_b ();

    pipe_hazard_ctrl                  dut_a (.clk(clk), .rst(rst), .hz(if_a.slave));
    pipe_hazard_ctrl #(.MAX_WAIT(3))  dut_b (.clk(clk), .rst(rst), .hz(if_b.slave));

    typedef struct {
        logic       rst;
        logic [3:0] src1, src2;
        logic       two;
        logic [3:0] ed;
        logic       ewb, emr;
        logic [3:0] md;
        logic       mwb, br, mreq, mrdy;
    } in_t;

    typedef struct {
        string      tag;
        logic       hf, iif, ief, gf, to_a, to_b;
        int         stall;
        logic       st;
        logic       chk_sel;
        logic [1:0] sel1, sel2;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

`ifdef FORWARD_EN
    localparam int B = 1;
`else
    localparam int B = 2;
`endif

    function automatic in_t mi(logic r, logic [3:0] s1, logic [3:0] s2, logic two,
                               logic [3:0] ed, logic ewb, logic emr, logic [3:0] md,
                               logic mwb, logic br, logic mreq, logic mrdy);
        in_t v;
        v.rst = r; v.src1 = s1; v.src2 = s2; v.two = two; v.ed = ed; v.ewb = ewb;
        v.emr = emr; v.md = md; v.mwb = mwb; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
        return v;
    endfunction

    function automatic exp_t mk(string tag, logic hf, logic iif, logic ief, logic gf,
                                logic to_a, logic to_b, int stall, logic st);
        exp_t e;
        e.tag = tag; e.hf = hf; e.iif = iif; e.ief = ief; e.gf = gf;
        e.to_a = to_a; e.to_b = to_b; e.stall = stall; e.st = st;
        e.chk_sel = 1'b0; e.sel1 = 2'b00; e.sel2 = 2'b00;
        return e;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        rst = v.rst;
        if_a.id_src1 = v.src1;    if_b.id_src1 = v.src1;
        if_a.id_src2 = v.src2;    if_b.id_src2 = v.src2;
        if_a.id_two_src = v.two;  if_b.id_two_src = v.two;
        if_a.exe_dest = v.ed;     if_b.exe_dest = v.ed;
        if_a.exe_wb_en = v.ewb;   if_b.exe_wb_en = v.ewb;
        if_a.exe_mem_r_en = v.emr; if_b.exe_mem_r_en = v.emr;
        if_a.mem_dest = v.md;     if_b.mem_dest = v.md;
        if_a.mem_wb_en = v.mwb;   if_b.mem_wb_en = v.mwb;
        if_a.branch_taken = v.br; if_b.branch_taken = v.br;
        if_a.mem_req = v.mreq;    if_b.mem_req = v.mreq;
        if_a.mem_ready = v.mrdy;  if_b.mem_ready = v.mrdy;
    endtask

    // Inputs change just after the rising edge; the monitor samples on the falling edge.
    task automatic step(input in_t v, input exp_t e);
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "hazard_freeze", 32'(if_a.hazard_freeze), 32'(e.hf));
            chk(e.tag, "if_id_flush",   32'(if_a.if_id_flush),   32'(e.iif));
            chk(e.tag, "id_exe_flush",  32'(if_a.id_exe_flush),  32'(e.ief));
            chk(e.tag, "global_freeze", 32'(if_a.global_freeze), 32'(e.gf));
            chk(e.tag, "timeout_a",     32'(if_a.mem_timeout),   32'(e.to_a));
            chk(e.tag, "timeout_b",     32'(if_b.mem_timeout),   32'(e.to_b));
            chk(e.tag, "stall_a",       32'(if_a.stall_cycles),  e.stall);
            chk(e.tag, "stall_b",       32'(if_b.stall_cycles),  e.stall);
            chk(e.tag, "state_a",       32'(dut_a.state),        32'(e.st));
`ifdef FORWARD_EN
            if (e.chk_sel) begin
                chk(e.tag, "sel_src1", 32'(if_a.sel_src1), 32'(e.sel1));
                chk(e.tag, "sel_src2", 32'(if_a.sel_src2), 32'(e.sel2));
            end
`endif
        end
    end

    initial begin
        in_t  idle, mw, v;
        exp_t e;
        idle = mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mw   = mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset: registers clear, combinational freeze still follows inputs
        step(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0));
        step(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mk("rst_gf",   0, 0, 0, 1, 0, 0, 0, 0));
        step(idle,                                    mk("post_rst", 0, 0, 0, 0, 0, 0, 0, 0));

        // Four-cycle memory wait with a hazard and a branch masked by the freeze
        v = mi(1, 3, 0, 0, 3, 1, 0, 0, 0, 1, 1, 0);
        step(v, mk("frz1", 0, 0, 0, 1, 0, 0, 0, 0));
        step(v, mk("frz2", 0, 0, 0, 1, 0, 0, 1, 1));
        step(v, mk("frz3", 0, 0, 0, 1, 0, 0, 2, 1));
        step(v, mk("frz4", 0, 0, 0, 1, 0, 0, 3, 1));
        step(mi(1, 3, 0, 0, 3, 1, 0, 0, 0, 1, 1, 1), mk("frz_br",   0, 1, 1, 0, 0, 1, 4, 1));
        step(idle,                                    mk("frz_done", 0, 0, 0, 0, 0, 1, 4, 0));

        step(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk("rst_async", 0, 0, 0, 0, 0, 0, 0, 0));

        // Data hazards
`ifdef FORWARD_EN
        e = mk("fwd_nostall", 0, 0, 0, 0, 0, 0, 0, 0);
        e.chk_sel = 1; e.sel1 = 2'b00; e.sel2 = 2'b01;
        step(mi(1, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0), e);
        v = mi(1, 0, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        e = mk("load_use", 1, 0, 1, 0, 0, 0, 0, 0);
        e.chk_sel = 1; e.sel1 = 2'b00; e.sel2 = 2'b01;
        step(v, e);
        v.br = 1;
        e = mk("br_hz", 0, 1, 1, 0, 0, 0, B, 0);
        e.chk_sel = 1; e.sel1 = 2'b00; e.sel2 = 2'b01;
        step(v, e);
`else
        step(mi(1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0), mk("raw_exe", 1, 0, 1, 0, 0, 0, 0, 0));
        v = mi(1, 3, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step(v, mk("raw_mem", 1, 0, 1, 0, 0, 0, 1, 0));
        v.br = 1;
        step(v, mk("br_hz",   0, 1, 1, 0, 0, 0, B, 0));
`endif
        step(idle, mk("idle", 0, 0, 0, 0, 0, 0, B, 0));

        // Five-cycle wait: MAX_WAIT=3 instance times out, flag is sticky
        step(mw, mk("to_w1", 0, 0, 0, 1, 0, 0, B,     0));
        step(mw, mk("to_w2", 0, 0, 0, 1, 0, 0, B + 1, 1));
        step(mw, mk("to_w3", 0, 0, 0, 1, 0, 0, B + 2, 1));
        step(mw, mk("to_w4", 0, 0, 0, 1, 0, 0, B + 3, 1));
        step(mw, mk("to_w5", 0, 0, 0, 1, 0, 1, B + 4, 1));
        step(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), mk("to_rdy",    0, 0, 0, 0, 0, 1, B + 5, 1));
        step(idle,                                    mk("to_sticky", 0, 0, 0, 0, 0, 1, B + 5, 0));

        // Reset in the middle of a wait
        step(mw, mk("mw_a", 0, 0, 0, 1, 0, 1, B + 5, 0));
        step(mw, mk("mw_b", 0, 0, 0, 1, 0, 1, B + 6, 1));
        step(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mk("rst_mid", 0, 0, 0, 1, 0, 0, 0, 0));
        step(idle, mk("rst_rel",   0, 0, 0, 0, 0, 0, 0, 0));
        step(mw,   mk("restart_w", 0, 0, 0, 1, 0, 0, 0, 0));
        step(idle, mk("restart_m", 0, 0, 0, 0, 0, 0, 1, 1));
        step(idle, mk("restart_r", 0, 0, 0, 0, 0, 0, 1, 0));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        chk("drain", "queue_left", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
